// File: rtl/dhash_compare.sv
// dhash_compare: motion detector fed by the dHash signature generator.
//
// Each incoming 64-bit signature is either latched as the reference or
// compared with it. A compare XORs the two, counts the set bits one byte
// per cycle for eight cycles, then tests the distance against a
// programmable threshold and raises motionDetected.
// The custom-instruction (CI) port gives access to status, results and
// configuration.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   sigValid            one-cycle pulse: sigData carries a new signature
//   sigData             64-bit signature
//   takeSignature       1 = store as reference, 0 = compare
//   ciStart, ciN        CI request strobe and opcode (matched to CustomId)
//   ciValueA, ciValueB  CI operation select [2:0] and write data
//   ciDone, ciResult    registered one-cycle completion and read data
//   motionDetected      level result of the last completed compare
//   resultValid         one-cycle pulse when distance/motionDetected update
//   busy                compare in progress

module dhash_compare #(
   parameter logic [7:0] CustomId         = 8'h28,
   parameter logic [6:0] DefaultThreshold = 7'd10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        sigValid,
   input  logic [63:0] sigData,
   input  logic        takeSignature,
   input  logic        ciStart,
   input  logic [7:0]  ciN,
   input  logic [31:0] ciValueA,
   input  logic [31:0] ciValueB,
   output logic        ciDone,
   output logic [31:0] ciResult,
   output logic        motionDetected,
   output logic        resultValid,
   output logic        busy
);

   typedef enum logic [1:0] {
      StIdle,
      StCount,
      StDecide
   } state_e;

   state_e      state_q, state_d;
   logic [63:0] reference_q, reference_d;
   logic        ref_valid_q, ref_valid_d;
   logic [63:0] diff_q, diff_d;
   logic [6:0]  acc_q, acc_d;
   logic [2:0]  chunk_q, chunk_d;
   logic [6:0]  distance_q, distance_d;
   logic        motion_q, motion_d;
   logic        result_valid_q, result_valid_d;
   logic [31:0] compare_count_q, compare_count_d;
   logic [7:0]  dropped_q, dropped_d;
   logic [6:0]  threshold_q, threshold_d;
   logic        ci_done_q, ci_done_d;
   logic [31:0] ci_result_q, ci_result_d;

   logic        ci_hit;
   logic [2:0]  ci_op;
   logic        clear_op;
   logic        thr_wr;
   logic [6:0]  thr_new;
   logic [6:0]  thr_eff;
   logic [7:0]  chunk_byte;
   logic [3:0]  chunk_ones;
   logic        unused_ci_bits;

   assign unused_ci_bits = ^{ciValueA[31:3], ciValueB[31:7]};

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   assign ci_hit     = ciStart && (ciN == CustomId);
   assign ci_op      = ciValueA[2:0];
   assign clear_op   = ci_hit && (ci_op == 3'd5);
   assign thr_wr     = ci_hit && (ci_op == 3'd4);
   assign thr_new    = (ciValueB[6:0] > 7'd64) ? 7'd64 : ciValueB[6:0];
   // A threshold write on the DECIDE edge already applies to that decision.
   assign thr_eff    = thr_wr ? thr_new : threshold_q;
   assign chunk_byte = diff_q[{chunk_q, 3'b000} +: 8];
   assign chunk_ones = popcount8(chunk_byte);

   always_comb begin
      state_d         = state_q;
      reference_d     = reference_q;
      ref_valid_d     = ref_valid_q;
      diff_d          = diff_q;
      acc_d           = acc_q;
      chunk_d         = chunk_q;
      distance_d      = distance_q;
      motion_d        = motion_q;
      result_valid_d  = 1'b0;
      compare_count_d = compare_count_q;
      dropped_d       = dropped_q;
      threshold_d     = threshold_q;
      ci_done_d       = 1'b0;
      ci_result_d     = 32'd0;

      // CI reads see the values held before this edge's updates.
      if (ci_hit) begin
         ci_done_d = 1'b1;
         unique case (ci_op)
            3'd0: ci_result_d = {25'd0, distance_q};
            3'd1: ci_result_d = {16'd0, dropped_q, 5'd0, ref_valid_q,
                                 (state_q != StIdle), motion_q};
            3'd2: ci_result_d = reference_q[31:0];
            3'd3: ci_result_d = reference_q[63:32];
            3'd4: ci_result_d = {25'd0, threshold_q};
            3'd5: ci_result_d = 32'd0;
            3'd6: ci_result_d = compare_count_q;
            3'd7: ci_result_d = {25'd0, threshold_q};
            default: ci_result_d = 32'd0;
         endcase
      end

      if (thr_wr) begin
         threshold_d = thr_new;
      end
      if (clear_op) begin
         ref_valid_d = 1'b0;
         dropped_d   = 8'd0;
      end

      unique case (state_q)
         StCount: begin
            acc_d   = acc_q + {3'b000, chunk_ones};
            chunk_d = chunk_q + 3'd1;
            if (chunk_q == 3'd7) begin
               state_d = StDecide;
            end
            if (sigValid && !clear_op && (dropped_q != 8'hFF)) begin
               dropped_d = dropped_q + 8'd1;
            end
         end
         StIdle, StDecide: begin
            if (state_q == StDecide) begin
               distance_d      = acc_q;
               motion_d        = (acc_q > thr_eff);
               compare_count_d = compare_count_q + 32'd1;
               result_valid_d  = 1'b1;
               state_d         = StIdle;
            end
            if (sigValid) begin
               // A concurrent clear makes the reference invalid, so the
               // incoming signature is stored rather than compared.
               if (!ref_valid_q || takeSignature || clear_op) begin
                  reference_d = sigData;
                  ref_valid_d = 1'b1;
               end else begin
                  diff_d  = sigData ^ reference_q;
                  acc_d   = 7'd0;
                  chunk_d = 3'd0;
                  state_d = StCount;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= StIdle;
         reference_q     <= 64'd0;
         ref_valid_q     <= 1'b0;
         diff_q          <= 64'd0;
         acc_q           <= 7'd0;
         chunk_q         <= 3'd0;
         distance_q      <= 7'd0;
         motion_q        <= 1'b0;
         result_valid_q  <= 1'b0;
         compare_count_q <= 32'd0;
         dropped_q       <= 8'd0;
         threshold_q     <= DefaultThreshold;
         ci_done_q       <= 1'b0;
         ci_result_q     <= 32'd0;
      end else begin
         state_q         <= state_d;
         reference_q     <= reference_d;
         ref_valid_q     <= ref_valid_d;
         diff_q          <= diff_d;
         acc_q           <= acc_d;
         chunk_q         <= chunk_d;
         distance_q      <= distance_d;
         motion_q        <= motion_d;
         result_valid_q  <= result_valid_d;
         compare_count_q <= compare_count_d;
         dropped_q       <= dropped_d;
         threshold_q     <= threshold_d;
         ci_done_q       <= ci_done_d;
         ci_result_q     <= ci_result_d;
      end
   end

   assign ciDone         = ci_done_q;
   assign ciResult       = ci_result_q;
   assign motionDetected = motion_q;
   assign resultValid    = result_valid_q;
   assign busy           = (state_q != StIdle);

endmodule
